// File: rtl/skylark_mem.sv
// skylark_mem: unified instruction/data memory with a byte-stream boot loader that holds the core in reset.
module skylark_mem #(
  parameter int DEPTH = 1024,
  parameter bit BOOT_EN = 1'b1,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  output logic [31:0] InstrF,
  input  logic [31:0] ALUResultW,
  input  logic [31:0] WriteData,
  input  logic        MemWriteW,
  output logic [31:0] ReadData,
  input  logic        load_valid,
  input  logic [7:0]  load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        core_reset,
  output logic        boot_done,
  output logic        load_ovf
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {LOAD, RUN} state_t;
  state_t state, nextState;
  logic [31:0] mem [DEPTH];
  logic [1:0] byteCnt;
  logic [AW:0] loadAddr;
  logic [31:0] asmReg, loadWord, memWd;
  logic [AW-1:0] memIdx;
  logic crQ, bdQ, accept, wordDue, memWe, pcOk, dOk;
  // Forcing the byte-offset bits high keeps them out of the range test without leaving them unused.
  assign pcOk = ((PCF | 32'd3) >> (AW + 2)) == 32'd0;
  assign dOk = ((ALUResultW | 32'd3) >> (AW + 2)) == 32'd0;
  assign core_reset = reset | crQ;
  assign boot_done = !reset & bdQ;
  assign load_ready = !reset && state == LOAD;
  assign InstrF = core_reset ? NOP_WORD : pcOk ? mem[PCF[AW+1:2]] : 32'd0;
  assign ReadData = core_reset ? 32'd0 : dOk ? mem[ALUResultW[AW+1:2]] : 32'd0;
  always_comb begin
    accept = load_valid && load_ready;
    wordDue = accept && (byteCnt == 2'd3 || load_last);
    loadWord = asmReg | (32'(load_data) << {byteCnt, 3'b000});
    nextState = (accept && load_last) ? RUN : state;
    memWe = !reset && (state == LOAD ? wordDue && !loadAddr[AW] : MemWriteW && dOk);
    memIdx = state == LOAD ? loadAddr[AW-1:0] : ALUResultW[AW+1:2];
    memWd = state == LOAD ? loadWord : WriteData;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT_EN ? LOAD : RUN;
      byteCnt <= '0;
      loadAddr <= '0;
      asmReg <= '0;
      load_ovf <= 1'b0;
      crQ <= BOOT_EN;
      bdQ <= !BOOT_EN;
    end else begin
      state <= nextState;
      crQ <= nextState == LOAD;
      bdQ <= nextState == RUN;
      if (accept) begin
        byteCnt <= wordDue ? 2'd0 : byteCnt + 2'd1;
        asmReg <= wordDue ? 32'd0 : loadWord;
      end
      if (wordDue) begin
        if (loadAddr[AW]) load_ovf <= 1'b1;
        else loadAddr <= loadAddr + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (memWe) mem[memIdx] <= memWd;
  end
endmodule

// File: tb/tb_skylark_mem.sv
// tb_skylark_mem: directed checks of boot loading, run-time loads/stores, overflow and reset behaviour.
module tb_skylark_mem;
  logic clk = 1'b0;
  logic [2:0] rst = 3'b111, lv = '0, ll = '0, mw = '0;
  logic [7:0] ld [3];
  logic [31:0] pc [3], alu [3], wd [3], instr [3], rd [3];
  logic [2:0] lr, cr, bd, ovf;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  skylark_mem #(.DEPTH(1024), .BOOT_EN(1'b1)) u0 (.clk(clk), .reset(rst[0]), .PCF(pc[0]), .InstrF(instr[0]),
    .ALUResultW(alu[0]), .WriteData(wd[0]), .MemWriteW(mw[0]), .ReadData(rd[0]), .load_valid(lv[0]),
    .load_data(ld[0]), .load_last(ll[0]), .load_ready(lr[0]), .core_reset(cr[0]), .boot_done(bd[0]), .load_ovf(ovf[0]));
  skylark_mem #(.DEPTH(4), .BOOT_EN(1'b1)) u1 (.clk(clk), .reset(rst[1]), .PCF(pc[1]), .InstrF(instr[1]),
    .ALUResultW(alu[1]), .WriteData(wd[1]), .MemWriteW(mw[1]), .ReadData(rd[1]), .load_valid(lv[1]),
    .load_data(ld[1]), .load_last(ll[1]), .load_ready(lr[1]), .core_reset(cr[1]), .boot_done(bd[1]), .load_ovf(ovf[1]));
  skylark_mem #(.DEPTH(16), .BOOT_EN(1'b0)) u2 (.clk(clk), .reset(rst[2]), .PCF(pc[2]), .InstrF(instr[2]),
    .ALUResultW(alu[2]), .WriteData(wd[2]), .MemWriteW(mw[2]), .ReadData(rd[2]), .load_valid(lv[2]),
    .load_data(ld[2]), .load_last(ll[2]), .load_ready(lr[2]), .core_reset(cr[2]), .boot_done(bd[2]), .load_ovf(ovf[2]));

  task automatic send_byte(input int k, input logic [7:0] b, input logic last);
    @(negedge clk);
    lv[k] = 1'b1; ld[k] = b; ll[k] = last;
    @(posedge clk); #1;
    lv[k] = 1'b0; ll[k] = 1'b0;
  endtask

  task automatic pulse_reset(input int k);
    @(negedge clk); rst[k] = 1'b1;
    @(negedge clk); rst[k] = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk); #1;
    checks++; if (lr[0] !== 1'b0) begin errors++; $display("FAIL rst_cycle_ready got %b exp 0", lr[0]); end
    checks++; if (cr[0] !== 1'b1) begin errors++; $display("FAIL rst_cycle_core_reset got %b exp 1", cr[0]); end
    rst[0] = 1'b0; #1;
    checks++; if (lr[0] !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", lr[0]); end
    checks++; if (cr[0] !== 1'b1) begin errors++; $display("FAIL reset_core_reset got %b exp 1", cr[0]); end
    checks++; if (bd[0] !== 1'b0) begin errors++; $display("FAIL reset_boot_done got %b exp 0", bd[0]); end
    for (int a = 0; a < 12; a += 4) begin
      pc[0] = a; #1;
      checks++; if (instr[0] !== 32'h00000013) begin errors++; $display("FAIL reset_nop pc=%0d got %h exp 00000013", a, instr[0]); end
    end
  endtask

  task automatic test_boot_load;
    logic [7:0] img [8] = '{8'h13, 8'h05, 8'h50, 8'h00, 8'hB3, 8'h05, 8'hB5, 8'h00};
    for (int i = 0; i < 8; i++) send_byte(0, img[i], i == 7);
    checks++; if (cr[0] !== 1'b0) begin errors++; $display("FAIL boot_core_reset got %b exp 0", cr[0]); end
    checks++; if (bd[0] !== 1'b1) begin errors++; $display("FAIL boot_done got %b exp 1", bd[0]); end
    checks++; if (lr[0] !== 1'b0) begin errors++; $display("FAIL boot_ready got %b exp 0", lr[0]); end
    pc[0] = 0; #1;
    checks++; if (instr[0] !== 32'h00500513) begin errors++; $display("FAIL boot_mem0 got %h exp 00500513", instr[0]); end
    pc[0] = 4; #1;
    checks++; if (instr[0] !== 32'h00B505B3) begin errors++; $display("FAIL boot_mem1 got %h exp 00B505B3", instr[0]); end
  endtask

  task automatic test_store;
    @(negedge clk); alu[0] = 32'h8; wd[0] = 32'h11111111; mw[0] = 1'b1;
    @(posedge clk); #1; mw[0] = 1'b0; #1;
    checks++; if (rd[0] !== 32'h11111111) begin errors++; $display("FAIL store_first got %h exp 11111111", rd[0]); end
    @(negedge clk); wd[0] = 32'hDEADBEEF; mw[0] = 1'b1; #1;
    checks++; if (rd[0] !== 32'h11111111) begin errors++; $display("FAIL store_old got %h exp 11111111", rd[0]); end
    @(posedge clk); #1; mw[0] = 1'b0; #1;
    checks++; if (rd[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL store_new got %h exp DEADBEEF", rd[0]); end
    alu[0] = 32'hA; #1;
    checks++; if (rd[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL store_unaligned got %h exp DEADBEEF", rd[0]); end
    @(negedge clk); alu[0] = 32'h1000; wd[0] = 32'h55555555; mw[0] = 1'b1; #1;
    checks++; if (rd[0] !== 32'h0) begin errors++; $display("FAIL oor_read got %h exp 00000000", rd[0]); end
    @(posedge clk); #1; mw[0] = 1'b0; alu[0] = 32'h0; #1;
    checks++; if (rd[0] !== 32'h00500513) begin errors++; $display("FAIL oor_write_dropped got %h exp 00500513", rd[0]); end
  endtask

  task automatic test_partial_load;
    for (int g = 0; g < 2; g++) begin
      pulse_reset(0);
      for (int i = 1; i <= 7; i++) begin
        send_byte(0, 8'(i), i == 7);
        if (g == 1 && i == 3) repeat (3) @(posedge clk);
      end
      pc[0] = 0; #1;
      checks++; if (instr[0] !== 32'h04030201) begin errors++; $display("FAIL partial%0d_mem0 got %h exp 04030201", g, instr[0]); end
      pc[0] = 4; #1;
      checks++; if (instr[0] !== 32'h00070605) begin errors++; $display("FAIL partial%0d_mem1 got %h exp 00070605", g, instr[0]); end
      checks++; if (ovf[0] !== 1'b0) begin errors++; $display("FAIL partial%0d_ovf got %b exp 0", g, ovf[0]); end
    end
  endtask

  task automatic test_mid_load_reset;
    pulse_reset(0);
    send_byte(0, 8'hAA, 1'b0);
    send_byte(0, 8'hBB, 1'b0);
    pulse_reset(0);
    send_byte(0, 8'h11, 1'b0);
    send_byte(0, 8'h22, 1'b0);
    send_byte(0, 8'h33, 1'b0);
    send_byte(0, 8'h44, 1'b1);
    pc[0] = 0; #1;
    checks++; if (instr[0] !== 32'h44332211) begin errors++; $display("FAIL midreset_mem0 got %h exp 44332211", instr[0]); end
    pc[0] = 4; #1;
    checks++; if (instr[0] !== 32'h00070605) begin errors++; $display("FAIL midreset_retained got %h exp 00070605", instr[0]); end
  endtask

  task automatic test_overflow;
    @(negedge clk); rst[1] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      send_byte(1, 8'(i), i == 20);
      if (i == 16) begin
        checks++; if (ovf[1] !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", ovf[1]); end
      end
    end
    checks++; if (ovf[1] !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", ovf[1]); end
    checks++; if (bd[1] !== 1'b1) begin errors++; $display("FAIL ovf_boot_done got %b exp 1", bd[1]); end
    pc[1] = 0; #1;
    checks++; if (instr[1] !== 32'h04030201) begin errors++; $display("FAIL ovf_nowrap got %h exp 04030201", instr[1]); end
    pc[1] = 32'hC; #1;
    checks++; if (instr[1] !== 32'h100F0E0D) begin errors++; $display("FAIL ovf_mem3 got %h exp 100F0E0D", instr[1]); end
    @(negedge clk); alu[1] = 32'h10; wd[1] = 32'hDEADBEEF; mw[1] = 1'b1; #1;
    checks++; if (rd[1] !== 32'h0) begin errors++; $display("FAIL ovf_oor_read got %h exp 00000000", rd[1]); end
    @(posedge clk); #1; mw[1] = 1'b0; alu[1] = 32'h0; pc[1] = 32'h10; #1;
    checks++; if (rd[1] !== 32'h04030201) begin errors++; $display("FAIL ovf_store_dropped got %h exp 04030201", rd[1]); end
    checks++; if (instr[1] !== 32'h0) begin errors++; $display("FAIL ovf_oor_fetch got %h exp 00000000", instr[1]); end
  endtask

  task automatic test_no_boot;
    @(negedge clk); #1;
    checks++; if (cr[2] !== 1'b1 || bd[2] !== 1'b0) begin errors++; $display("FAIL noboot_rst_cycle got cr=%b bd=%b exp cr=1 bd=0", cr[2], bd[2]); end
    rst[2] = 1'b0; #1;
    checks++; if (bd[2] !== 1'b1) begin errors++; $display("FAIL noboot_done got %b exp 1", bd[2]); end
    checks++; if (cr[2] !== 1'b0) begin errors++; $display("FAIL noboot_core_reset got %b exp 0", cr[2]); end
    checks++; if (lr[2] !== 1'b0) begin errors++; $display("FAIL noboot_ready got %b exp 0", lr[2]); end
    alu[2] = 32'h4; wd[2] = 32'hCAFEF00D; mw[2] = 1'b1;
    @(posedge clk); #1; mw[2] = 1'b0;
    send_byte(2, 8'h99, 1'b1);
    pulse_reset(2);
    #1;
    checks++; if (bd[2] !== 1'b1) begin errors++; $display("FAIL noboot_rerun got %b exp 1", bd[2]); end
    pc[2] = 32'h4; #1;
    checks++; if (rd[2] !== 32'hCAFEF00D) begin errors++; $display("FAIL noboot_retained_data got %h exp CAFEF00D", rd[2]); end
    checks++; if (instr[2] !== 32'hCAFEF00D) begin errors++; $display("FAIL noboot_retained_fetch got %h exp CAFEF00D", instr[2]); end
    checks++; if (ovf[2] !== 1'b0) begin errors++; $display("FAIL noboot_ovf got %b exp 0", ovf[2]); end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      ld[k] = '0; pc[k] = '0; alu[k] = '0; wd[k] = '0;
    end
    repeat (2) @(posedge clk);
    test_reset();
    test_boot_load();
    test_store();
    test_partial_load();
    test_mid_load_reset();
    test_overflow();
    test_no_boot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
